// File: rtl/au_pkg.sv
// Shared definitions for the 4-bit Arithmetic Unit.
//   div_state_t : sequential divider control states (IDLE / RUN / DONE)
//   AU_WIDTH    : datapath width of the AU operands and results
//   OP_*        : operation decoder opcodes; OP_DIV selects the divider slot
package au_pkg;

  localparam int AU_WIDTH = 4;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } div_state_t;

endpackage

// File: rtl/au_div_step.sv
// One combinational restoring-division iteration.
// Ports:
//   r       in  WIDTH  current partial remainder (always < divisor for divisor != 0)
//   dbit    in  1      next dividend bit, shifted in at the LSB
//   divisor in  WIDTH  unsigned divisor
//   r_next  out WIDTH  partial remainder after this step (restored on borrow)
//   qbit    out 1      quotient bit produced by this step
module au_div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] r,
  input  logic             dbit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] r_next,
  output logic             qbit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   sub_b;
  logic [WIDTH-1:0] diff;
  logic             carry;

  function automatic logic fa_sum(input logic a, input logic b, input logic ci);
    return a ^ b ^ ci;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic ci);
    return (a & b) | (ci & (a ^ b));
  endfunction

  function automatic logic [WIDTH-1:0] mux2(input logic sel,
                                             input logic [WIDTH-1:0] a0,
                                             input logic [WIDTH-1:0] a1);
    return sel ? a1 : a0;
  endfunction

  // Subtraction as shifted + ~{0,divisor} + 1 through a full-adder ripple;
  // the final carry-out doubles as the "no borrow" quotient bit. Only the
  // carry of the top stage matters, its sum bit is discarded by the restore.
  always_comb begin
    shifted = {r, dbit};
    sub_b   = ~{1'b0, divisor};
    carry   = 1'b1;
    diff    = '0;
    for (int i = 0; i < WIDTH; i++) begin
      diff[i] = fa_sum(shifted[i], sub_b[i], carry);
      carry   = fa_carry(shifted[i], sub_b[i], carry);
    end
    qbit   = fa_carry(shifted[WIDTH], sub_b[WIDTH], carry);
    r_next = mux2(qbit, shifted[WIDTH-1:0], diff);
  end

endmodule

// File: rtl/au_seq_divider.sv
// Multi-cycle unsigned restoring divider for the AU divide slot (OP_DIV).
// One quotient bit per clock, MSB first; results are held until the next
// accepted start.
// Optional build macro: AU_DIV_ZERO_FAST_EN -- a zero divisor skips RUN and
// goes straight to DONE with the same result values.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   start       in   request, accepted only while ready=1
//   dividend    in   WIDTH unsigned dividend, sampled on the accepting edge
//   divisor     in   WIDTH unsigned divisor, sampled on the accepting edge
//   ready       out  high in IDLE and DONE
//   busy        out  high in RUN
//   done        out  one-cycle pulse while in DONE
//   quotient    out  WIDTH registered quotient
//   remainder   out  WIDTH registered remainder
//   div_by_zero out  registered, set when the latched divisor is zero
module au_seq_divider
  import au_pkg::*;
#(
  parameter int WIDTH = AU_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

`ifdef AU_DIV_ZERO_FAST_EN
  localparam logic FAST_DZ = 1'b1;
`else
  localparam logic FAST_DZ = 1'b0;
`endif

  div_state_t       state, state_next;
  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] dvd_sh;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-2:0] q_acc;
  logic [WIDTH-1:0] r_next;
  logic [WIDTH-1:0] q_next;
  logic             qbit;
  logic             accept;
  logic             dz_fast;
  logic             last_step;

  assign accept    = start && (state != ST_RUN);
  assign dz_fast   = FAST_DZ && (divisor == '0);
  assign last_step = (state == ST_RUN) && (count == '0);
  assign q_next    = {q_acc, qbit};

  au_div_step #(.WIDTH(WIDTH)) u_step (
    .r       (r_acc),
    .dbit    (dvd_sh[WIDTH-1]),
    .divisor (dvs),
    .r_next  (r_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    ready      = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) state_next = dz_fast ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (count == '0) state_next = ST_DONE;
      end
      ST_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
        if (start) state_next = dz_fast ? ST_DONE : ST_RUN;
        else       state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= '0;
      dvd_sh      <= '0;
      dvs         <= '0;
      r_acc       <= '0;
      q_acc       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvd_sh      <= dividend;
      dvs         <= divisor;
      r_acc       <= '0;
      q_acc       <= '0;
      count       <= CNT_W'(WIDTH - 1);
      div_by_zero <= (divisor == '0);
      // Fast path produces the same values the full iteration would.
      if (dz_fast) begin
        quotient  <= '1;
        remainder <= dividend;
      end
    end else if (state == ST_RUN) begin
      dvd_sh <= {dvd_sh[WIDTH-2:0], 1'b0};
      r_acc  <= r_next;
      q_acc  <= q_next[WIDTH-2:0];
      if (last_step) begin
        quotient  <= q_next;
        remainder <= r_next;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: doc/au_seq_divider.md
Name: au_seq_divider

Overview:
- Multi-cycle unsigned restoring divider for the 4-bit Arithmetic Unit.
- Occupies the divide slot selected by the operation decoder, opcode 2'b11.
- Latches operands under a start/ready handshake and resolves one quotient bit per clock, MSB first.
- Holds quotient, remainder and divide-by-zero flag stable for the AU result mux until the next accepted start.

Parameters:
- WIDTH, 4, operand/quotient/remainder width; the supported and verified value is 4.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; accepted only when ready=1
- dividend  input  WIDTH  unsigned dividend, sampled on the accepting edge
- divisor  input  WIDTH  unsigned divisor, sampled on the accepting edge
- ready  output  1  high in IDLE and DONE
- busy  output  1  high in RUN
- done  output  1  one-cycle pulse when the result becomes valid
- quotient  output  WIDTH  registered quotient
- remainder  output  WIDTH  registered remainder
- div_by_zero  output  1  registered; set when the latched divisor == 0

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset (async assert, any state): state=IDLE, quotient=0, remainder=0, div_by_zero=0, done=0, busy=0, ready=1, iteration count=0.
- A reset mid-RUN aborts the operation silently; no done pulse follows.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 accepts: latch dividend/divisor into shift registers, clear the partial remainder, count=WIDTH-1, set div_by_zero=(divisor==0), go to RUN.
  - quotient and remainder keep their previous values until DONE.
- RUN, one step per edge:
  - shifted = {R, next dividend bit}, WIDTH+1 bits.
  - diff = shifted - {0, divisor}, computed by a ripple of full adders with divisor inverted and cin=1.
  - carry-out=1 (no borrow): q bit=1, R=diff[WIDTH-1:0]. Otherwise q bit=0, R=shifted[WIDTH-1:0] (restore).
  - R always stays < divisor, so WIDTH bits suffice (divisor=0 case excepted).
  - When count==0, the step result is written to quotient/remainder and the state goes to DONE; otherwise count decrements.
- DONE:
  - done=1 for exactly this cycle; ready=1.
  - With start=1, accepts like IDLE (back-to-back), with no done in the next cycle.
  - With start=0, goes to IDLE.
- Latency: start accepted at edge E0 -> done high in the cycle after edge E(WIDTH), i.e. 5 cycles after start for WIDTH=4.
- start while busy=1 is ignored; operand changes during RUN are ignored.
- Divide by zero (no macro): the natural algorithm runs all WIDTH steps and yields quotient=all-ones, remainder=dividend, div_by_zero=1.
- div_by_zero holds until the next accepted start.

Optional Feature:
- Macro: AU_DIV_ZERO_FAST_EN.
- Defined: divisor==0 at acceptance goes IDLE->DONE directly and loads quotient=all-ones, remainder=dividend, div_by_zero=1. done pulses in the cycle after the accepting edge; busy never asserts.
- Undefined: the full WIDTH-cycle RUN, with identical result values.
- Non-zero divisors behave identically either way.

Decomposition:
- Shared package au_pkg holds:
  - the state enum (IDLE/RUN/DONE);
  - the AU_WIDTH=4 constant;
  - the opcode constants (OP_DIV=2'b11 among them).
- Sub-module au_div_step: combinational single restoring iteration.
  - Inputs: R, dividend bit, divisor.
  - Outputs: next R, q bit.
  - Built from the team's full_adder chain plus the 4-bit 2:1 mux for the restore selection.
- The top level holds the FSM, counter and registers only.

Test Plan:
- 13/3: start one cycle, hold inputs -> busy for 4 cycles; done in cycle 5 after start; quotient=4, remainder=1, div_by_zero=0.
- Values 15/1 -> 15 r0; 2/9 -> 0 r2; 9/9 -> 1 r0.
- 7/0:
  - macro off -> done after 5 cycles, quotient=4'hF, remainder=7, div_by_zero=1;
  - macro on -> same values, done 1 cycle after start, busy never high.
- Start 12/5, then during RUN pulse start with 1/1 and change the operands -> new request ignored; result 2 r2.
- Async rst_n low in the 2nd RUN cycle -> all outputs 0, ready=1 immediately; no done; a new 6/4 afterwards -> 1 r2.
- Back-to-back: start held high through DONE with 10/3 then 8/2 -> 3 r1 in the first DONE, second accepted on that edge; 4 r0 five cycles later.
